// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } tx_feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: storage array, wrapping pointers and an occupancy count.
// Full/empty come from the count so a wrapped pointer pair is never ambiguous.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count define validity, so stale
    // contents are never observable and the array can map onto plain RAM.
    always_ff @(posedge i_Clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer feeding a UART transmitter: one strobe per
// byte, then wait for the transmitter's done pulse before the next launch.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clock,
    input  logic             i_Rst_L,
    input  logic             i_Wr_DV,
    input  logic [7:0]       i_Wr_Byte,
    output logic             o_Wr_Ready,
    output logic             o_Tx_DV,
    output logic [7:0]       o_Tx_Byte,
    input  logic             i_Tx_Active,
    input  logic             i_Tx_Done,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Empty,
    output logic             o_Overflow
);

    tx_feed_state_t         state;
    tx_feed_state_t         next_state;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [UART_DATA_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .wr_en   (i_Wr_DV),
        .wr_data (i_Wr_Byte),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (o_Count)
    );

    assign o_Wr_Ready = !full;
    assign o_Empty    = empty;
    assign o_Tx_DV    = (state == LAUNCH);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !i_Tx_Active) begin
                    pop        = 1'b1;
                    next_state = LAUNCH;
                end
            end
            LAUNCH:    next_state = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The overflow check uses the start-of-cycle full flag, so a write landing
    // on the same edge as a pop from a full FIFO is still dropped and flagged.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            o_Tx_Byte  <= '0;
            o_Overflow <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) o_Tx_Byte <= head;
            if (i_Wr_DV && full) o_Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, single launch, ordered drain,
// full/overflow, wrap-around, busy gating and reset mid-transmit.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_dv = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       tx_active = 1'b0;
    logic       tx_done_man = 1'b0;
    logic       tx_done_auto = 1'b0;
    logic       auto_tx = 1'b0;
    logic       tx_done;
    logic       wr_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [4:0] count;
    logic       empty;
    logic       overflow;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    logic [7:0] strobe_q[$];
    int         strobe_t[$];
    logic [7:0] exp_q[$];

    assign tx_done = tx_done_man | tx_done_auto;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Wr_Ready  (wr_ready),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Count     (count),
        .o_Empty     (empty),
        .o_Overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every launched byte and the edge count it started on.
    always @(negedge clk) begin
        if (tx_dv) begin
            strobe_q.push_back(tx_byte);
            strobe_t.push_back(cyc);
        end
    end

    // Automatic transmitter: done pulse a few cycles after each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_tx && tx_dv) begin
                repeat (4) @(posedge clk);
                #1 tx_done_auto = 1'b1;
                @(posedge clk);
                #1 tx_done_auto = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done();
        tx_done_man = 1'b1;
        done_cyc    = cyc;
        tick();
        tx_done_man = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int i = 0;
        while (strobe_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        check("strobe_count", strobe_q.size(), n);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_empty"},    empty,    1);
        check({tag, "_tx_dv"},    tx_dv,    0);
        check({tag, "_tx_byte"},  tx_byte,  0);
        check({tag, "_count"},    count,    0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        // Power-up reset
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("por");

        // Single byte: strobe one cycle after the write edge
        wr_dv = 1'b1; wr_byte = 8'hA5;
        tick();
        wr_dv = 1'b0;
        check("single_count_after_wr", count, 1);
        check("single_no_early_dv", tx_dv, 0);
        check("single_not_empty", empty, 0);
        tick();
        check("single_dv", tx_dv, 1);
        check("single_byte", tx_byte, 8'hA5);
        check("single_count_after_pop", count, 0);
        tick();
        check("single_dv_one_cycle", tx_dv, 0);
        repeat (3) tick();
        check("single_byte_held", tx_byte, 8'hA5);
        pulse_done();
        tick();

        // Ordered drain: done 20 cycles after each strobe, next strobe 2 cycles after done
        strobe_q.delete(); strobe_t.delete();
        for (int i = 1; i <= 4; i++) begin
            wr_dv = 1'b1; wr_byte = 8'(i);
            tick();
        end
        wr_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_strobes(k + 1, 100);
            if (strobe_q.size() > k) begin
                check("drain_byte", strobe_q[k], 8'(k + 1));
                if (k > 0) check("drain_gap", strobe_t[k] - done_cyc, 2);
                while (cyc < strobe_t[k] + 20) tick();
            end
            pulse_done();
        end
        repeat (3) tick();

        // Full / overflow with the transmitter held busy
        strobe_q.delete(); strobe_t.delete();
        tx_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h40 + 8'(i);
            tick();
            if (i == 15) begin
                check("full_wr_ready", wr_ready, 0);
                check("full_count16", count, 16);
                check("full_no_ovf_yet", overflow, 0);
            end
        end
        wr_dv = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_no_strobe", strobe_q.size(), 0);
        repeat (3) tick();
        check("ovf_sticky", overflow, 1);

        // Write on the same edge as a pop from full: write still rejected
        auto_tx = 1'b1;
        tx_active = 1'b0;
        wr_dv = 1'b1; wr_byte = 8'h99;
        tick();
        wr_dv = 1'b0;
        check("pop_full_count", count, 15);
        check("pop_full_dv", tx_dv, 1);
        check("pop_full_byte", tx_byte, 8'h40);
        wait_strobes(16, 400);
        repeat (20) tick();
        check("full_drain_total", strobe_q.size(), 16);
        for (int i = 0; i < 16 && i < strobe_q.size(); i++)
            check("full_drain_byte", strobe_q[i], 8'h40 + 8'(i));
        check("ovf_still_sticky", overflow, 1);

        // Wrap-around: 40 writes paced by wr_ready, drained concurrently
        strobe_q.delete(); strobe_t.delete();
        for (int i = 0; i < 40; i++) begin
            int g = 0;
            while (!wr_ready && g < 200) begin
                tick();
                g++;
            end
            wr_dv = 1'b1; wr_byte = 8'(i * 37 + 5);
            exp_q.push_back(8'(i * 37 + 5));
            tick();
            wr_dv = 1'b0;
            if (i % 5 == 4) repeat (3) tick();
        end
        wait_strobes(40, 2000);
        for (int i = 0; i < 40 && i < strobe_q.size(); i++)
            check("wrap_byte", strobe_q[i], exp_q[i]);
        repeat (10) tick();
        auto_tx = 1'b0;
        check("wrap_empty", empty, 1);

        // Busy gating and stray done in IDLE
        strobe_q.delete(); strobe_t.delete();
        tx_active = 1'b1;
        wr_dv = 1'b1; wr_byte = 8'h3C;
        tick();
        wr_dv = 1'b0;
        repeat (8) tick();
        check("busy_no_strobe", strobe_q.size(), 0);
        check("busy_count", count, 1);
        pulse_done();
        repeat (3) tick();
        check("stray_done_no_strobe", strobe_q.size(), 0);
        tx_active = 1'b0;
        wait_strobes(1, 10);
        check("busy_release_byte", tx_byte, 8'h3C);
        repeat (2) tick();
        pulse_done();
        tick();

        // Reset mid-transmit with three bytes queued
        strobe_q.delete(); strobe_t.delete();
        for (int i = 0; i < 4; i++) begin
            wr_dv = 1'b1; wr_byte = 8'hB1 + 8'(i);
            tick();
        end
        wr_dv = 1'b0;
        repeat (2) tick();
        check("mid_count3", count, 3);
        check("mid_one_strobe", strobe_q.size(), 1);
        tx_active = 1'b1;
        rst_n = 1'b0;
        tick();
        check_reset_values("mid_rst");
        rst_n = 1'b1;
        tick();
        tx_active = 1'b0;
        pulse_done();
        repeat (5) tick();
        check("late_done_no_strobe", strobe_q.size(), 1);
        check("late_done_dv", tx_dv, 0);
        check("late_done_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
